// File: rtl/ifetch_line_buffer_if.sv
// Fetch-side and instruction-memory-side signals of the single-line fetch buffer.
// The buffer uses the master modport; the fetch stage and memory model use slave.
interface ifetch_line_buffer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              stall;
  logic              fetch_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    input  pc, flush, mem_ack, mem_rdata,
    output instr, instr_valid, stall, fetch_err, mem_req, mem_addr
  );

  modport slave (
    output pc, flush, mem_ack, mem_rdata,
    input  instr, instr_valid, stall, fetch_err, mem_req, mem_addr
  );
endinterface

// File: rtl/ifetch_line_buffer.sv
// One-line instruction buffer: zero-latency hits, in-order line fill over req/ack on a miss.
// A flush during a fill lets the fill finish but leaves the line invalid.
module ifetch_line_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ifetch_line_buffer_if.master  bus
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF   = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_reg;
  logic              line_valid_reg;
  logic [TAG_W-1:0]  line_tag_reg;
  logic [IDX_W-1:0]  cnt_reg;
  logic              flush_pend_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       line_buf [LINE_WORDS];

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  cnt_inc;
  logic              misaligned;
  logic              hit;
  logic              fill_ack;

  assign pc_tag     = bus.pc[ADDR_W-1:OFF];
  assign pc_idx     = bus.pc[OFF-1:2];
  assign misaligned = |bus.pc[1:0];
  assign hit        = line_valid_reg && (line_tag_reg == pc_tag);
  assign cnt_inc    = cnt_reg + 1'b1;
  assign fill_ack   = (state_reg == FILL) && bus.mem_ack;

  assign bus.mem_req  = mem_req_reg;
  assign bus.mem_addr = mem_addr_reg;

  // Hit path is purely combinational; stall is held low while reset is asserted.
  always_comb begin
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.fetch_err   = 1'b0;
    if (state_reg == FILL) begin
      bus.stall = 1'b1;
    end else if (misaligned) begin
      bus.fetch_err = 1'b1;
    end else if (hit) begin
      bus.instr       = line_buf[pc_idx];
      bus.instr_valid = 1'b1;
    end else begin
      bus.stall = 1'b1;
    end
    if (reset) begin
      bus.stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fill_ack) begin
      line_buf[cnt_reg] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      line_valid_reg <= 1'b0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            line_valid_reg <= 1'b0;
          end
          if (!misaligned && !hit) begin
            line_tag_reg   <= pc_tag;
            cnt_reg        <= '0;
            line_valid_reg <= 1'b0;
            mem_req_reg    <= 1'b1;
            mem_addr_reg   <= {pc_tag, {IDX_W{1'b0}}, 2'b00};
            state_reg      <= FILL;
          end
        end
        FILL: begin
          if (bus.flush) begin
            flush_pend_reg <= 1'b1;
          end
          if (bus.mem_ack) begin
            if (cnt_reg == LAST_IDX) begin
              line_valid_reg <= ~(flush_pend_reg | bus.flush);
              flush_pend_reg <= 1'b0;
              cnt_reg        <= '0;
              mem_req_reg    <= 1'b0;
              state_reg      <= IDLE;
            end else begin
              cnt_reg      <= cnt_inc;
              mem_addr_reg <= {line_tag_reg, cnt_inc, 2'b00};
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
